uart_rx_host: RTL and testbench

- Host-side serial receiver that recovers the bytes sent by the player-side message register and UART transmit path.
- Samples the asynchronous `rx_serial` line, frames 8N1 characters (LSB first) and presents each good byte with a one-cycle `rx_ready` strobe.
- Flags framing errors, and parity errors when the optional feature is compiled in.
- Feeds the host-side message handling and display logic.

---
 rtl/uart_rx_host.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_host.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_host.sv
// uart_rx_host: 8N1 serial receiver, 2-flop input synchronizer, optional even parity (UART_RX_PARITY_EN).
// Latency: rx_ready pulses HALF+9*CLKS_PER_BIT+1 cycles after start detect (+CLKS_PER_BIT with parity).
// Backpressure: none; each good byte is a one-cycle strobe and rx_byte holds until the next good byte.
module uart_rx_host #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       framing_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    state_t           state, state_nxt;
    logic             sync1, rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             cnt_clr, cnt_inc, idx_clr, shift_en;
    logic             done_ok, done_ferr;
`ifdef UART_RX_PARITY_EN
    logic             par_bit, par_en, done_perr;
`endif

    // Synchronizer resets to 1 so a reset line reads as idle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_serial;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        done_ok   = 1'b0;
        done_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en    = 1'b0;
        done_perr = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_clr   = 1'b1;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr   = 1'b1;
                    idx_clr   = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_M1) begin
                    cnt_clr   = 1'b1;
                    par_en    = 1'b1;
                    state_nxt = STOP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift, par_bit}) done_perr = 1'b1;
                        else                   done_ok   = 1'b1;
`else
                        done_ok = 1'b1;
`endif
                    end else begin
                        // A low stop bit wins over any parity outcome.
                        done_ferr = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            rx_byte     <= 8'h00;
            rx_ready    <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CNT_W'(1);
            if (idx_clr) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
            if (done_ok) rx_byte <= shift;
            rx_ready    <= done_ok;
            framing_err <= done_ferr;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_en) par_bit <= rx_s;
            parity_err <= done_perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_host.sv
// tb_uart_rx_host: randomized self-checking bench for uart_rx_host at CLKS_PER_BIT=16.
// Latency: each expected pulse cycle is derived from the frame start and the bit timing rules.
// Backpressure: none; a monitor logs every output pulse, test tasks compare against a frame-level model.
module tb_uart_rx_host;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Drive happens just after edge 'cyc'; the first sync flop samples at edge cyc+1 (A),
    // T0 = A+2, and the pulse is visible just after edge T0+HALF+9*CPB (the pulse cycle T0+HALF+9*CPB+1).
    localparam int LAT = 3 + HALF + 9 * CPB + (PAR_EN ? CPB : 0);

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_ready, framing_err, parity_err, busy;

    uart_rx_host #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .nRst(nRst), .rx_serial(rx_serial), .rx_byte(rx_byte),
        .rx_ready(rx_ready), .framing_err(framing_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;
    // kind: 0 = rx_ready, 1 = framing_err, 2 = parity_err; dat is rx_byte at the pulse
    int         got_kind[$], got_cyc[$], exp_kind[$], exp_cyc[$];
    logic [7:0] got_dat[$], exp_dat[$];

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (rx_ready)    begin got_kind.push_back(0); got_dat.push_back(rx_byte); got_cyc.push_back(cyc); end
        if (framing_err) begin got_kind.push_back(1); got_dat.push_back(rx_byte); got_cyc.push_back(cyc); end
        if (parity_err)  begin got_kind.push_back(2); got_dat.push_back(rx_byte); got_cyc.push_back(cyc); end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        tick(CPB);
    endtask

    task automatic clear_q();
        got_kind.delete(); got_dat.delete(); got_cyc.delete();
        exp_kind.delete(); exp_dat.delete(); exp_cyc.delete();
    endtask

    // Frame-level model: bad stop -> framing error; else bad even parity -> parity error; else new byte.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        int k;
        k = cyc + LAT;
        if (!stop_bit) begin
            exp_kind.push_back(1); exp_dat.push_back(last_good); exp_cyc.push_back(k);
        end else if (PAR_EN && (^{d, par_bit})) begin
            exp_kind.push_back(2); exp_dat.push_back(last_good); exp_cyc.push_back(k);
        end else begin
            last_good = d;
            exp_kind.push_back(0); exp_dat.push_back(d); exp_cyc.push_back(k);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        tick(3);
        n_cmp++;
        if ({rx_byte, rx_ready, framing_err, parity_err, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got byte=%02h rdy=%b ferr=%b perr=%b busy=%b, expected all 0",
                     rx_byte, rx_ready, framing_err, parity_err, busy);
        end
        @(negedge clk) nRst = 1'b1;
        tick(4);
        n_cmp++;
        if ({rx_byte, rx_ready, framing_err, parity_err, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got byte=%02h rdy=%b ferr=%b perr=%b busy=%b, expected all 0",
                     rx_byte, rx_ready, framing_err, parity_err, busy);
        end
    endtask

    task automatic test_basic();
        clear_q();
        send_frame(8'h41, 1'b1, ^8'h41);
        rx_serial = 1'b1;
        tick(CPB);
        n_cmp++;
        if (got_kind.size() != exp_kind.size()) begin
            n_fail++; $display("FAIL basic_count: got %0d pulses, expected %0d", got_kind.size(), exp_kind.size());
        end
        for (int i = 0; i < got_kind.size() && i < exp_kind.size(); i++) begin
            n_cmp++;
            if (got_kind[i] !== exp_kind[i] || got_dat[i] !== exp_dat[i] || got_cyc[i] !== exp_cyc[i]) begin
                n_fail++;
                $display("FAIL basic_ev%0d: got kind=%0d byte=%02h cyc=%0d, expected kind=%0d byte=%02h cyc=%0d",
                         i, got_kind[i], got_dat[i], got_cyc[i], exp_kind[i], exp_dat[i], exp_cyc[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || rx_byte !== 8'h41) begin
            n_fail++; $display("FAIL basic_after: got busy=%b byte=%02h, expected busy=0 byte=41", busy, rx_byte);
        end
    endtask

    task automatic test_glitch();
        clear_q();
        rx_serial = 1'b0;
        tick(3);
        rx_serial = 1'b1;
        tick(2);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL glitch_busy: got busy=%b, expected 1 while start is checked", busy);
        end
        tick(2 * CPB);
        n_cmp++;
        if (got_kind.size() != 0 || rx_byte !== last_good || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_after: got pulses=%0d byte=%02h busy=%b, expected pulses=0 byte=%02h busy=0",
                     got_kind.size(), rx_byte, busy, last_good);
        end
    endtask

    task automatic test_break();
        clear_q();
        send_frame(8'h55, 1'b0, ^8'h55);
        rx_serial = 1'b0;
        tick(40 * CPB);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL break_busy: got busy=%b, expected 1 while the line is held low", busy);
        end
        rx_serial = 1'b1;
        tick(CPB);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL break_release: got busy=%b, expected 0 once the line is high", busy);
        end
        send_frame(8'hA3, 1'b1, ^8'hA3);
        rx_serial = 1'b1;
        tick(CPB);
        n_cmp++;
        if (got_kind.size() != exp_kind.size()) begin
            n_fail++; $display("FAIL break_count: got %0d pulses, expected %0d", got_kind.size(), exp_kind.size());
        end
        for (int i = 0; i < got_kind.size() && i < exp_kind.size(); i++) begin
            n_cmp++;
            if (got_kind[i] !== exp_kind[i] || got_dat[i] !== exp_dat[i] || got_cyc[i] !== exp_cyc[i]) begin
                n_fail++;
                $display("FAIL break_ev%0d: got kind=%0d byte=%02h cyc=%0d, expected kind=%0d byte=%02h cyc=%0d",
                         i, got_kind[i], got_dat[i], got_cyc[i], exp_kind[i], exp_dat[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] frames [3];
        frames = '{8'h00, 8'hFF, 8'h7E};
        clear_q();
        for (int i = 0; i < 3; i++) send_frame(frames[i], 1'b1, ^frames[i]);
        rx_serial = 1'b1;
        tick(CPB);
        n_cmp++;
        if (got_kind.size() != exp_kind.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d pulses, expected %0d", got_kind.size(), exp_kind.size());
        end
        for (int i = 0; i < got_kind.size() && i < exp_kind.size(); i++) begin
            n_cmp++;
            if (got_kind[i] !== exp_kind[i] || got_dat[i] !== exp_dat[i] || got_cyc[i] !== exp_cyc[i]) begin
                n_fail++;
                $display("FAIL b2b_ev%0d: got kind=%0d byte=%02h cyc=%0d, expected kind=%0d byte=%02h cyc=%0d",
                         i, got_kind[i], got_dat[i], got_cyc[i], exp_kind[i], exp_dat[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h3C;
        clear_q();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        #1 nRst = 1'b0;
        #1;
        n_cmp++;
        if ({rx_byte, rx_ready, framing_err, parity_err, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL midframe_reset: got byte=%02h rdy=%b ferr=%b perr=%b busy=%b, expected all 0",
                     rx_byte, rx_ready, framing_err, parity_err, busy);
        end
        rx_serial = 1'b1;
        last_good = 8'h00;
        tick(3);
        @(negedge clk) nRst = 1'b1;
        tick(2 * CPB);
        send_frame(8'hC3, 1'b1, ^8'hC3);
        rx_serial = 1'b1;
        tick(CPB);
        n_cmp++;
        if (got_kind.size() != exp_kind.size()) begin
            n_fail++; $display("FAIL midframe_count: got %0d pulses, expected %0d", got_kind.size(), exp_kind.size());
        end
        for (int i = 0; i < got_kind.size() && i < exp_kind.size(); i++) begin
            n_cmp++;
            if (got_kind[i] !== exp_kind[i] || got_dat[i] !== exp_dat[i] || got_cyc[i] !== exp_cyc[i]) begin
                n_fail++;
                $display("FAIL midframe_ev%0d: got kind=%0d byte=%02h cyc=%0d, expected kind=%0d byte=%02h cyc=%0d",
                         i, got_kind[i], got_dat[i], got_cyc[i], exp_kind[i], exp_dat[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       bad_stop, bad_par;
        clear_q();
        for (int f = 0; f < 24; f++) begin
            d        = 8'($urandom);
            bad_stop = ($urandom_range(0, 4) == 0);
            bad_par  = PAR_EN && ($urandom_range(0, 3) == 0);
            send_frame(d, !bad_stop, (^d) ^ bad_par);
            rx_serial = 1'b1;
            tick($urandom_range(4, 2 * CPB));
        end
        tick(CPB);
        n_cmp++;
        if (got_kind.size() != exp_kind.size()) begin
            n_fail++; $display("FAIL random_count: got %0d pulses, expected %0d", got_kind.size(), exp_kind.size());
        end
        for (int i = 0; i < got_kind.size() && i < exp_kind.size(); i++) begin
            n_cmp++;
            if (got_kind[i] !== exp_kind[i] || got_dat[i] !== exp_dat[i] || got_cyc[i] !== exp_cyc[i]) begin
                n_fail++;
                $display("FAIL random_ev%0d: got kind=%0d byte=%02h cyc=%0d, expected kind=%0d byte=%02h cyc=%0d",
                         i, got_kind[i], got_dat[i], got_cyc[i], exp_kind[i], exp_dat[i], exp_cyc[i]);
            end
        end
        n_cmp++;
        if (rx_byte !== last_good) begin
            n_fail++; $display("FAIL random_hold: got byte=%02h, expected %02h", rx_byte, last_good);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_q();
        send_frame(8'h07, 1'b1, 1'b1);
        rx_serial = 1'b1;
        tick(4);
        send_frame(8'h07, 1'b1, 1'b0);
        rx_serial = 1'b1;
        tick(4);
        send_frame(8'h18, 1'b0, 1'b1);
        rx_serial = 1'b1;
        tick(CPB);
        n_cmp++;
        if (got_kind.size() != exp_kind.size()) begin
            n_fail++; $display("FAIL parity_count: got %0d pulses, expected %0d", got_kind.size(), exp_kind.size());
        end
        for (int i = 0; i < got_kind.size() && i < exp_kind.size(); i++) begin
            n_cmp++;
            if (got_kind[i] !== exp_kind[i] || got_dat[i] !== exp_dat[i] || got_cyc[i] !== exp_cyc[i]) begin
                n_fail++;
                $display("FAIL parity_ev%0d: got kind=%0d byte=%02h cyc=%0d, expected kind=%0d byte=%02h cyc=%0d",
                         i, got_kind[i], got_dat[i], got_cyc[i], exp_kind[i], exp_dat[i], exp_cyc[i]);
            end
        end
        n_cmp++;
        if (rx_byte !== 8'h07) begin
            n_fail++; $display("FAIL parity_hold: got byte=%02h, expected 07", rx_byte);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
